dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Controller that sits in front of the single-port word-addressed data memory (`dmem`) and shares it between the pipeline MEM stage (port C) and a debug/loader port (port D). It arbitrates with CPU priority plus a starvation guard, turns byte stores into a two-cycle read-modify-write of a full word, and drives `dmem` with word writes only (`b` held at 0). The pipeline derives its MEM-stage stall from `c_req & ~c_ready`.

## Interface
Parameters:
- `STARVE_LIMIT`, 4: consecutive contested cycles port C may win before port D is forced to win.

Ports:
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `c_req`  in  1  port C request; held with fields stable until `c_ready`
- `c_we`  in  1  port C write (1) / read (0)
- `c_byte`  in  1  port C byte store (only meaningful with `c_we`)
- `c_addr`  in  32  port C byte address
- `c_wdata`  in  32  port C write data; byte store uses `[7:0]`
- `c_rdata`  out  32  port C read data, valid when `c_ready & ~c_we`
- `c_ready`  out  1  port C transaction completes this cycle
- `d_req`, `d_we`, `d_byte`, `d_addr`, `d_wdata`, `d_rdata`, `d_ready`: port D, same widths and meaning
- `mem_we`  out  1  to `dmem.we`
- `mem_a`  out  32  to `dmem.a`
- `mem_wd`  out  32  to `dmem.wd`
- `mem_b`  out  1  to `dmem.b`; constant 0
- `mem_rd`  in  32  from `dmem.rd` (combinational read)

## Operation
- States: `IDLE`, `RMW_WR`.
- `IDLE` arbitration: only one requesting → it wins. Both requesting → C wins unless `starve_cnt == STARVE_LIMIT`, then D wins.
- `starve_cnt`: in `IDLE`, +1 when both request and C wins (saturating at `STARVE_LIMIT`); cleared when D is granted or `d_req` is 0.
- Winner read: `mem_a` = winner addr, `mem_we`=0, winner `ready`=1, `rdata`=`mem_rd`. Stay `IDLE`.
- Winner word write: `mem_we`=1, `mem_wd`=winner wdata, `ready`=1. Stay `IDLE`.
- Winner byte store: cycle 1 `mem_we`=0, `mem_a`=addr, register `mem_rd` into `rmw_word`, register owner; `ready`=0; → `RMW_WR`.
- `RMW_WR`: `mem_we`=1, `mem_a`=owner addr, `mem_wd` = `rmw_word` with lane `addr[1:0]` (bits `[8k+7:8k]`, k=`addr[1:0]`) replaced by wdata`[7:0]`; owner `ready`=1; other port `ready`=0 regardless of request; → `IDLE`. No arbitration in this state; `starve_cnt` holds.
- Loser and idle port: `ready`=0, `rdata`=`mem_rd` (don't-care).
- Addresses forwarded unmodified; word alignment is applied by `dmem` (`a[31:2]`).

## Timing
- Reset (async assert, sync-to-`clk` deassert by top): state `IDLE`, `starve_cnt`=0, `rmw_word`=0, owner=C. Outputs in reset: `mem_we`=0, `c_ready`=`d_ready`=0, `mem_b`=0.
- Reset asserted while in `RMW_WR`: merged write is aborted (`mem_we` forced 0); no partial store.
- Latency: read and word write 1 cycle (ready in request cycle, write commits at that edge). Byte store 2 cycles (ready in second).
- Back-to-back: a new request may be accepted in the cycle after `ready`; `IDLE` sustains one transaction per cycle.
- Requester dropping `req` before `ready` is illegal; if it occurs in `RMW_WR` the write still completes.
- `STARVE_LIMIT`=0: D wins every contested cycle.

## Structure
- Package `dmem_ctrl_pkg`: state enum (`IDLE`, `RMW_WR`), owner enum (`OWN_C`, `OWN_D`), `BYTE_LANES`=4.
- Sub-module `byte_merge` (combinational): inputs word, byte, lane[1:0]; output merged word. Reused by the verification model.

## Test plan
- Word at 0x10 = 0x11223344; C byte store addr 0x12, wdata 0xAB → cycle 1 `c_ready`=0, cycle 2 `mem_we`=1, `mem_wd`=0x11AB3344; subsequent C read 0x10 returns 0x11AB3344.
- C and D both request reads continuously, `STARVE_LIMIT`=4 → C granted 4 cycles, D 1, repeating pattern C×4,D×1.
- D byte store in progress (`RMW_WR`) while C requests word write → C `ready`=0 that cycle, granted the next; both values present in memory.
- Only D requests word write 0xDEADBEEF at 0x20 → `d_ready`=1 same cycle; `c_ready`=0; read 0x20 returns 0xDEADBEEF.
- `reset_n` dropped during `RMW_WR` of byte store to 0x30 (original 0x00000000) → no write; after reset word at 0x30 still 0, all readies 0.
- Byte stores to lanes 0–3 of 0x40 (wdata 0x01,0x02,0x03,0x04) → final word 0x04030201.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   state_t  : controller state (IDLE, RMW_WR)
//   owner_t  : port that owns an in-flight byte-store read-modify-write
//   BYTE_LANES : byte lanes per memory word
package dmem_ctrl_pkg;

    typedef enum logic {
        IDLE,
        RMW_WR
    } state_t;

    typedef enum logic {
        OWN_C,
        OWN_D
    } owner_t;

    localparam int BYTE_LANES = 4;

endpackage

// File: rtl/byte_merge.sv
// Replaces one byte lane of a 32-bit word.
//   word   in  32  original word
//   wbyte  in  8   replacement byte
//   lane   in  2   lane index k; bits [8k+7:8k] are replaced
//   merged out 32  word with the lane replaced
module byte_merge
    import dmem_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [7:0]  wbyte,
    input  logic [1:0]  lane,
    output logic [31:0] merged
);

    always_comb begin
        for (int k = 0; k < BYTE_LANES; k++) begin
            merged[8*k +: 8] = (lane == 2'(k)) ? wbyte : word[8*k +: 8];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port, word-addressed data memory between the pipeline
// MEM stage (port C) and a debug/loader port (port D). Port C has priority
// with a starvation guard for D; byte stores become a two-cycle
// read-modify-write so the memory only ever sees full-word writes.
//   clk, reset_n                : clock, async active-low reset
//   c_req/c_we/c_byte/c_addr/c_wdata -> c_rdata/c_ready : port C
//   d_req/d_we/d_byte/d_addr/d_wdata -> d_rdata/d_ready : port D
//   mem_we/mem_a/mem_wd/mem_b -> dmem, mem_rd <- dmem (combinational read)
module dmem_arbiter
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        c_req,
    input  logic        c_we,
    input  logic        c_byte,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic [31:0] c_rdata,
    output logic        c_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_byte,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_b,
    input  logic [31:0] mem_rd
);

    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           state_q, state_d;
    owner_t           owner_q, owner_d;
    logic [31:0]      rmw_q, rmw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        starve_hit, grant_c, grant_d;
    logic        sel_we, sel_byte;
    logic [31:0] sel_addr, sel_wdata;
    logic [31:0] own_addr, own_wdata, merged;

    // Winner selection only matters in IDLE; RMW_WR ignores it.
    assign starve_hit = (cnt_q == LIMIT);
    assign grant_d    = d_req & (~c_req | starve_hit);
    assign grant_c    = c_req & ~grant_d;

    assign sel_we    = grant_d ? d_we    : c_we;
    assign sel_byte  = grant_d ? d_byte  : c_byte;
    assign sel_addr  = grant_d ? d_addr  : c_addr;
    assign sel_wdata = grant_d ? d_wdata : c_wdata;

    // The owner keeps its fields stable until ready, so the second RMW cycle
    // takes address and byte straight from the owning port.
    assign own_addr  = (owner_q == OWN_D) ? d_addr  : c_addr;
    assign own_wdata = (owner_q == OWN_D) ? d_wdata : c_wdata;

    byte_merge u_merge (
        .word   (rmw_q),
        .wbyte  (own_wdata[7:0]),
        .lane   (own_addr[1:0]),
        .merged (merged)
    );

    assign c_rdata = mem_rd;
    assign d_rdata = mem_rd;
    assign mem_b   = 1'b0;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= OWN_C;
            rmw_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rmw_q   <= rmw_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path through the case leaves a signal unassigned (no latches).
        state_d = state_q;
        owner_d = owner_q;
        rmw_d   = rmw_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;
        mem_a   = c_addr;
        mem_wd  = c_wdata;
        c_ready = 1'b0;
        d_ready = 1'b0;

        case (state_q)
            IDLE: begin
                if (!d_req || grant_d) begin
                    cnt_d = '0;
                end else if (grant_c && cnt_q != LIMIT) begin
                    cnt_d = cnt_q + 1'b1;
                end

                if (grant_c || grant_d) begin
                    mem_a = sel_addr;
                    if (sel_we && sel_byte) begin
                        // First half of a byte store: capture the old word.
                        rmw_d   = mem_rd;
                        owner_d = grant_d ? OWN_D : OWN_C;
                        state_d = RMW_WR;
                    end else begin
                        mem_we  = sel_we;
                        mem_wd  = sel_wdata;
                        c_ready = grant_c;
                        d_ready = grant_d;
                    end
                end
            end

            RMW_WR: begin
                mem_we  = 1'b1;
                mem_a   = own_addr;
                mem_wd  = merged;
                c_ready = (owner_q == OWN_C);
                d_ready = (owner_q == OWN_D);
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        // While reset is held nothing may reach memory, which also aborts
        // a merged write that was about to commit.
        if (!reset_n) begin
            mem_we  = 1'b0;
            c_ready = 1'b0;
            d_ready = 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter. A small word memory model sits on
// the memory side. Stimulus tasks push expected completions and expected
// memory writes into queues; a negedge monitor pops and compares whenever
// the DUT raises a ready or a write enable.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        c_req, c_we, c_byte;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic        c_ready;
    logic        d_req, d_we, d_byte;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        d_ready;
    logic        mem_we, mem_b;
    logic [31:0] mem_a, mem_wd, mem_rd;

    // Second instance with STARVE_LIMIT = 0 (D must win every contest).
    logic        c_ready0, d_ready0, mem_we0, mem_b0;
    logic [31:0] c_rdata0, d_rdata0, mem_a0, mem_wd0;

    int checks = 0;
    int errors = 0;
    bit contest = 1'b0;

    typedef struct {
        logic        port;      // 0 = C, 1 = D
        logic        is_read;
        logic [31:0] rdata;
    } txn_t;

    typedef struct {
        logic [29:0] widx;
        logic [31:0] data;
    } wr_t;

    txn_t exp_txn[$];
    wr_t  exp_wr[$];

    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[7:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_a[7:2]] <= mem_wd;
    end

    dmem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .c_req(c_req), .c_we(c_we), .c_byte(c_byte), .c_addr(c_addr),
        .c_wdata(c_wdata), .c_rdata(c_rdata), .c_ready(c_ready),
        .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_b(mem_b),
        .mem_rd(mem_rd)
    );

    dmem_arbiter #(.STARVE_LIMIT(0)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .c_req(c_req), .c_we(c_we), .c_byte(c_byte), .c_addr(c_addr),
        .c_wdata(c_wdata), .c_rdata(c_rdata0), .c_ready(c_ready0),
        .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata0), .d_ready(d_ready0),
        .mem_we(mem_we0), .mem_a(mem_a0), .mem_wd(mem_wd0), .mem_b(mem_b0),
        .mem_rd(mem_rd)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every completion and every memory write.
    always @(negedge clk) begin
        txn_t t;
        wr_t  w;
        if (c_ready && d_ready) check("both_ready", 32'd1, 32'd0);
        if (c_ready || d_ready) begin
            if (exp_txn.size() == 0) begin
                check("unexpected_ready", {30'd0, d_ready, c_ready}, 32'd0);
            end else begin
                t = exp_txn.pop_front();
                check("ready_port", {31'd0, d_ready}, {31'd0, t.port});
                if (t.is_read) check("rdata", d_ready ? d_rdata : c_rdata, t.rdata);
            end
        end
        if (mem_we) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_write", mem_a, 32'hFFFF_FFFF);
            end else begin
                w = exp_wr.pop_front();
                check("wr_addr", {2'd0, mem_a[31:2]}, {2'd0, w.widx});
                check("wr_data", mem_wd, w.data);
            end
            check("mem_b", {31'd0, mem_b}, 32'd0);
        end
        if (contest) begin
            check("limit0_d_ready", {31'd0, d_ready0}, 32'd1);
            check("limit0_c_ready", {31'd0, c_ready0}, 32'd0);
        end
    end

    task automatic push_wr(input logic [31:0] addr, input logic [31:0] data);
        wr_t w;
        w.widx = addr[31:2];
        w.data = data;
        exp_wr.push_back(w);
    endtask

    task automatic push_txn(input logic port, input logic is_read,
                            input logic [31:0] rdata);
        txn_t t;
        t.port    = port;
        t.is_read = is_read;
        t.rdata   = rdata;
        exp_txn.push_back(t);
    endtask

    // Issue one transaction on a port; call just after a rising edge.
    task automatic txn(input string name, input logic port, input logic we,
                       input logic byt, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata_exp,
                       input int lat_exp);
        int  lat;
        logic rdy;
        push_txn(port, !we, rdata_exp);
        if (port) begin
            d_req = 1'b1; d_we = we; d_byte = byt; d_addr = addr; d_wdata = wdata;
        end else begin
            c_req = 1'b1; c_we = we; c_byte = byt; c_addr = addr; c_wdata = wdata;
        end
        lat = 0;
        rdy = 1'b0;
        while (!rdy && lat < 20) begin
            @(negedge clk);
            lat++;
            rdy = port ? d_ready : c_ready;
        end
        check({name, "_latency"}, lat, lat_exp);
        @(posedge clk);
        #1;
        if (port) d_req = 1'b0;
        else      c_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[4] = 32'h1122_3344;

        // Reset with a C word write pending: nothing may leak out.
        reset_n = 1'b0;
        c_req = 1'b1; c_we = 1'b1; c_byte = 1'b0; c_addr = 32'h10; c_wdata = 32'hFFFF_FFFF;
        d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_c_ready", {31'd0, c_ready}, 32'd0);
        check("rst_d_ready", {31'd0, d_ready}, 32'd0);
        check("rst_mem_we",  {31'd0, mem_we},  32'd0);
        check("rst_mem_b",   {31'd0, mem_b},   32'd0);
        c_req = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Byte store into lane 2 of 0x10, then read back.
        push_wr(32'h10, 32'h11AB_3344);
        txn("c_byte_12", 1'b0, 1'b1, 1'b1, 32'h12, 32'h0000_00AB, 32'h0, 2);
        txn("c_rd_10", 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h11AB_3344, 1);

        // D alone: word write then read.
        push_wr(32'h20, 32'hDEAD_BEEF);
        txn("d_wr_20", 1'b1, 1'b1, 1'b0, 32'h20, 32'hDEAD_BEEF, 32'h0, 1);
        txn("d_rd_20", 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF, 1);

        // Continuous contention: C x4, D x1, repeated twice.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) push_txn(1'b0, 1'b1, 32'h11AB_3344);
            push_txn(1'b1, 1'b1, 32'hDEAD_BEEF);
        end
        c_req = 1'b1; c_we = 1'b0; c_byte = 1'b0; c_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 32'h20;
        contest = 1'b1;
        repeat (10) @(negedge clk);
        contest = 1'b0;
        @(posedge clk); #1;
        c_req = 1'b0; d_req = 1'b0;

        // D byte store in flight while C asks for a word write.
        push_wr(32'h50, 32'h0000_5A00);
        push_wr(32'h54, 32'hCAFE_F00D);
        fork
            txn("d_byte_51", 1'b1, 1'b1, 1'b1, 32'h51, 32'h0000_005A, 32'h0, 2);
            begin
                @(posedge clk); #1;
                txn("c_wr_54_blocked", 1'b0, 1'b1, 1'b0, 32'h54, 32'hCAFE_F00D, 32'h0, 2);
            end
        join
        txn("c_rd_50", 1'b0, 1'b0, 1'b0, 32'h50, 32'h0, 32'h0000_5A00, 1);
        txn("c_rd_54", 1'b0, 1'b0, 1'b0, 32'h54, 32'h0, 32'hCAFE_F00D, 1);

        // Reset during the write half of a byte store to 0x30.
        c_req = 1'b1; c_we = 1'b1; c_byte = 1'b1; c_addr = 32'h30; c_wdata = 32'h77;
        @(negedge clk);
        check("rmw_c1_ready", {31'd0, c_ready}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("rmw_abort_we",    {31'd0, mem_we},  32'd0);
        check("rmw_abort_c_rdy", {31'd0, c_ready}, 32'd0);
        check("rmw_abort_d_rdy", {31'd0, d_ready}, 32'd0);
        c_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_c_ready", {31'd0, c_ready}, 32'd0);
        check("post_rst_d_ready", {31'd0, d_ready}, 32'd0);
        check("mem_30_untouched", mem[12], 32'd0);
        @(posedge clk); #1;
        txn("c_rd_30", 1'b0, 1'b0, 1'b0, 32'h30, 32'h0, 32'h0, 1);

        // Byte stores to all four lanes of 0x40.
        push_wr(32'h40, 32'h0000_0001);
        txn("c_byte_40", 1'b0, 1'b1, 1'b1, 32'h40, 32'h01, 32'h0, 2);
        push_wr(32'h40, 32'h0000_0201);
        txn("c_byte_41", 1'b0, 1'b1, 1'b1, 32'h41, 32'h02, 32'h0, 2);
        push_wr(32'h40, 32'h0003_0201);
        txn("c_byte_42", 1'b0, 1'b1, 1'b1, 32'h42, 32'h03, 32'h0, 2);
        push_wr(32'h40, 32'h0403_0201);
        txn("c_byte_43", 1'b0, 1'b1, 1'b1, 32'h43, 32'h04, 32'h0, 2);
        txn("c_rd_40", 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0403_0201, 1);

        repeat (2) @(negedge clk);
        check("txn_queue_empty", exp_txn.size(), 32'd0);
        check("wr_queue_empty",  exp_wr.size(),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
